// File: rtl/vga_frame_reader.sv
// vga_frame_reader
// Frame-buffer read controller feeding the VGA driver. Each `ready` strobe
// issues one synchronous-read address into the displayed bank, so the source
// image is replicated SCALE times horizontally and vertically. Bank swaps
// requested by the writer take effect only on the vsync falling edge.
// Latency ready -> pixel is two cycles: address register, then RAM read.

module vga_frame_reader #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int SCALE = 2,
  parameter int OFS_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             vsync,
  output logic [OFS_W:0]   rd_addr,
  output logic             rd_en,
  input  logic [11:0]      rd_data,
  output logic [11:0]      pixel,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             disp_bank,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int XS_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int X_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XS_W-1:0]  XS_LAST   = XS_W'(SCALE - 1);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [OFS_W-1:0] LINE_STEP = OFS_W'(IMG_W);

  // position state: replication counters and source coordinates
  logic [XS_W-1:0]  xs_r, xs_nxt_s;
  logic [X_W-1:0]   x_r, x_nxt_s;
  logic [XS_W-1:0]  ys_r, ys_nxt_s;
  logic [Y_W-1:0]   y_r, y_nxt_s;
  logic [OFS_W-1:0] line_base_r, line_base_nxt_s;
  logic             frame_end_s;

  logic             vsync_q_r;
  logic             valid_q_r;
  logic             vsync_fall_s;
  logic             frame_busy_s;
  logic [OFS_W-1:0] offset_s;

  // line_base tracks y*IMG_W incrementally, so the offset is a single add
  assign offset_s     = line_base_r + OFS_W'(x_r);
  assign vsync_fall_s = vsync_q_r & ~vsync;
  assign frame_busy_s = (|xs_r) | (|x_r) | (|ys_r) | (|y_r) | (|line_base_r);

  // next position: vsync resync wins over ready; nested wraps walk the frame
  always_comb begin
    xs_nxt_s        = xs_r;
    x_nxt_s         = x_r;
    ys_nxt_s        = ys_r;
    y_nxt_s         = y_r;
    line_base_nxt_s = line_base_r;
    frame_end_s     = 1'b0;
    if (!vsync) begin
      xs_nxt_s        = {XS_W{1'b0}};
      x_nxt_s         = {X_W{1'b0}};
      ys_nxt_s        = {XS_W{1'b0}};
      y_nxt_s         = {Y_W{1'b0}};
      line_base_nxt_s = {OFS_W{1'b0}};
    end else if (ready) begin
      if (xs_r == XS_LAST) begin
        xs_nxt_s = {XS_W{1'b0}};
        if (x_r == X_LAST) begin
          x_nxt_s = {X_W{1'b0}};
          if (ys_r == YS_LAST_F(1'b0)) begin
            ys_nxt_s = {XS_W{1'b0}};
            if (y_r == Y_LAST) begin
              y_nxt_s         = {Y_W{1'b0}};
              line_base_nxt_s = {OFS_W{1'b0}};
              frame_end_s     = 1'b1;
            end else begin
              y_nxt_s         = y_r + Y_W'(1);
              line_base_nxt_s = line_base_r + LINE_STEP;
            end
          end else begin
            ys_nxt_s = ys_r + XS_W'(1);
          end
        end else begin
          x_nxt_s = x_r + X_W'(1);
        end
      end else begin
        xs_nxt_s = xs_r + XS_W'(1);
      end
    end else begin
      xs_nxt_s = xs_r;
    end
  end

  // vertical replication shares the horizontal factor
  function automatic logic [XS_W-1:0] YS_LAST_F(input logic unused);
    return XS_LAST | {XS_W{unused}};
  endfunction

  // position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      xs_r        <= {XS_W{1'b0}};
      x_r         <= {X_W{1'b0}};
      ys_r        <= {XS_W{1'b0}};
      y_r         <= {Y_W{1'b0}};
      line_base_r <= {OFS_W{1'b0}};
    end else begin
      xs_r        <= xs_nxt_s;
      x_r         <= x_nxt_s;
      ys_r        <= ys_nxt_s;
      y_r         <= y_nxt_s;
      line_base_r <= line_base_nxt_s;
    end
  end

  // read request: one address per ready cycle, address held while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr   <= {(OFS_W + 1){1'b0}};
      valid_q_r <= 1'b0;
    end else begin
      valid_q_r <= rd_en;
      if (ready) begin
        rd_en   <= 1'b1;
        rd_addr <= {disp_bank, offset_s};
      end else begin
        rd_en   <= 1'b0;
      end
    end
  end

  // frame control: bank swap, sync error and end-of-frame strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q_r  <= 1'b1;
      disp_bank  <= 1'b0;
      swap_ack   <= 1'b0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync_q_r  <= vsync;
      frame_done <= frame_end_s;
      swap_ack   <= vsync_fall_s & swap_req;
      if (vsync_fall_s && swap_req) begin
        disp_bank <= ~disp_bank;
      end
      if (vsync_fall_s && frame_busy_s) begin
        sync_err <= 1'b1;
      end
    end
  end

  // blank the pixel whenever no read was issued two cycles earlier
  assign pixel = valid_q_r ? rd_data : 12'h000;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader with a reduced image geometry so whole frames
// are short. The reference model counts consumed pixels within a frame and
// derives the source offset by division; a RAM model supplies rd_data.

module tb_vga_frame_reader;

  localparam int IMG_W = 16;
  localparam int IMG_H = 12;
  localparam int SCALE = 2;
  localparam int OFS_W = 8;
  localparam int LINE_PIX = IMG_W * SCALE;
  localparam int TOTAL    = IMG_W * SCALE * IMG_H * SCALE;

  logic             clk;
  logic             rst;
  logic             ready;
  logic             vsync;
  logic [OFS_W:0]   rd_addr;
  logic             rd_en;
  logic [11:0]      rd_data;
  logic [11:0]      pixel;
  logic             swap_req;
  logic             swap_ack;
  logic             disp_bank;
  logic             frame_done;
  logic             sync_err;

  logic [11:0] mem [0:(2 * (2 ** OFS_W)) - 1];

  int n_checks = 0;
  int n_errors = 0;
  int fd_seen  = 0;
  logic sreq_lvl = 1'b0;

  // reference model state
  int             m_k;
  logic           m_bank, m_vs_q, m_err, m_fd, m_ack, m_rd_en;
  logic [OFS_W:0] m_rd_addr;
  logic [11:0]    m_pix;

  vga_frame_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE(SCALE), .OFS_W(OFS_W)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .vsync(vsync),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .pixel(pixel),
    .swap_req(swap_req), .swap_ack(swap_ack), .disp_bank(disp_bank),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read frame buffer
  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r_rst, input logic r_ready,
                            input logic r_vsync, input logic r_sreq);
    logic [11:0] nxt_pix;
    logic        fall;
    int          c, r, off;
    if (r_rst) begin
      m_k = 0; m_bank = 1'b0; m_vs_q = 1'b1; m_err = 1'b0; m_fd = 1'b0;
      m_ack = 1'b0; m_rd_en = 1'b0; m_rd_addr = '0; m_pix = 12'h000;
    end else begin
      nxt_pix = m_rd_en ? mem[m_rd_addr] : 12'h000;
      fall    = m_vs_q && !r_vsync;
      m_fd    = 1'b0;
      m_ack   = fall && r_sreq;
      if (r_ready) begin
        c   = m_k % LINE_PIX;
        r   = m_k / LINE_PIX;
        off = (r / SCALE) * IMG_W + c / SCALE;
        m_rd_en   = 1'b1;
        m_rd_addr = {m_bank, OFS_W'(off)};
      end else begin
        m_rd_en = 1'b0;
      end
      if (fall && m_k != 0) m_err = 1'b1;
      if (fall && r_sreq) m_bank = ~m_bank;
      if (!r_vsync) begin
        m_k = 0;
      end else if (r_ready) begin
        m_k++;
        if (m_k == TOTAL) begin
          m_k  = 0;
          m_fd = 1'b1;
        end
      end
      m_vs_q = r_vsync;
      m_pix  = nxt_pix;
    end
  endtask

  task automatic cycle(input logic r_rst, input logic r_ready, input logic r_vsync);
    rst = r_rst; ready = r_ready; vsync = r_vsync; swap_req = sreq_lvl;
    model_step(r_rst, r_ready, r_vsync, sreq_lvl);
    @(posedge clk);
    @(negedge clk);
    check("rd_en",      32'(rd_en),      32'(m_rd_en));
    check("rd_addr",    32'(rd_addr),    32'(m_rd_addr));
    check("pixel",      32'(pixel),      32'(m_pix));
    check("disp_bank",  32'(disp_bank),  32'(m_bank));
    check("swap_ack",   32'(swap_ack),   32'(m_ack));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("sync_err",   32'(sync_err),   32'(m_err));
    if (frame_done === 1'b1) fd_seen++;
    if (m_ack) sreq_lvl = 1'b0;
  endtask

  task automatic run_frame(input int drop_line, input int rst_at, input bit do_swap);
    int   pix;
    int   swap_pt;
    logic bank_start;
    pix     = 0;
    fd_seen = 0;
    swap_pt = do_swap ? int'($urandom_range(1, TOTAL - 1)) : -1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    bank_start = m_bank;
    for (int ln = 0; ln < IMG_H * SCALE; ln++) begin
      for (int p = 0; p < LINE_PIX; p++) begin
        if (pix == swap_pt) sreq_lvl = 1'b1;
        if (ln == drop_line && p >= 5 && p < 15) begin
          cycle(1'b0, 1'b0, 1'b1);
        end else begin
          if ($urandom_range(0, 15) == 0) cycle(1'b0, 1'b0, 1'b1);
          if (pix == rst_at) begin
            cycle(1'b1, 1'b1, 1'b1);
            check("bank_after_rst", 32'(disp_bank), 32'd0);
            check("rd_en_after_rst", 32'(rd_en), 32'd0);
          end else begin
            cycle(1'b0, 1'b1, 1'b1);
          end
          pix++;
        end
      end
      repeat ($urandom_range(2, 4)) cycle(1'b0, 1'b0, 1'b1);
    end
    check("frame_done_count", 32'(fd_seen),
          (drop_line < 0 && rst_at < 0) ? 32'd1 : 32'd0);
    if (rst_at < 0) check("bank_stable", 32'(disp_bank), 32'(bank_start));
  endtask

  initial begin
    for (int i = 0; i < 2 * (2 ** OFS_W); i++) mem[i] = 12'($urandom);
    rst = 1'b1; ready = 1'b0; vsync = 1'b1; swap_req = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    check("reset_pixel", 32'(pixel), 32'd0);
    check("reset_bank",  32'(disp_bank), 32'd0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);

    run_frame(-1, -1, 1'b0);
    run_frame(-1, -1, 1'b1);
    run_frame(-1, -1, 1'b0);
    run_frame(5, -1, 1'b0);
    run_frame(-1, -1, 1'b1);
    check("sync_err_sticky", 32'(sync_err), 32'd1);
    run_frame(-1, 100, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(-1, -1, 1'($urandom_range(0, 1)));
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
